// File: rtl/seg_scan_reader.sv
// seg_scan_reader: monitors the multiplexed 7-segment display bus.
// It synchronizes the active-low anode and cathode lines and waits for each
// digit pattern to hold steady. It then decodes the pattern back to BCD,
// collects the digits into a frame and flags any pattern or anode errors.
module seg_scan_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   anodo,
    input  logic [6:0]              catodo,
    input  logic                    enable,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic                    digit_valid,
    output logic [2:0]              digit_idx,
    output logic [3:0]              digit_val,
    output logic                    pattern_err,
    output logic                    err_sticky,
    output logic                    frame_done
);

    localparam int SW = NUM_DIGITS + 7;
    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] STABLE_PRE = 8'(STABLE_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] ONE_D = NUM_DIGITS'(1);

    typedef enum logic [1:0] {IDLE, TRACK, CAPTURED} state_t;

    state_t                state;
    logic [SW-1:0]         sync1;
    logic [SW-1:0]         sync2;
    logic [7:0]            cnt;
    logic [7:0]            cnt_next;
    logic [NUM_DIGITS-1:0] mask;
    logic [NUM_DIGITS-1:0] mask_new;
    logic [NUM_DIGITS-1:0] low_next;
    logic [NUM_DIGITS-1:0] low_cur;
    logic                  changed;
    logic                  none_next;
    logic                  one_next;
    logic                  capture;
    logic                  multi_err;
    logic [2:0]            cur_idx;
    logic [4:0]            dec;

    // Map an active-low segment pattern to {valid, bcd}; anything unknown is invalid
    function automatic logic [4:0] decode(input logic [6:0] c);
        logic [4:0] r;
        case (c)
            7'b0000001: r = {1'b1, 4'd0};
            7'b1001111: r = {1'b1, 4'd1};
            7'b0010010: r = {1'b1, 4'd2};
            7'b0000110: r = {1'b1, 4'd3};
            7'b1001100: r = {1'b1, 4'd4};
            7'b0100100: r = {1'b1, 4'd5};
            7'b0100000: r = {1'b1, 4'd6};
            7'b0001111: r = {1'b1, 4'd7};
            7'b0000000: r = {1'b1, 4'd8};
            7'b0000100: r = {1'b1, 4'd9};
            default:    r = 5'd0;
        endcase
        return r;
    endfunction

    // sync1 is the value S will take at the next edge, so state decisions look one step ahead
    assign low_next  = ~sync1[SW-1:7];
    assign low_cur   = ~sync2[SW-1:7];
    assign changed   = (sync1 != sync2);
    assign none_next = (low_next == '0);
    assign one_next  = !none_next && ((low_next & (low_next - ONE_D)) == '0);
    assign cnt_next  = changed ? 8'd1 : ((cnt < STABLE_MAX) ? cnt + 8'd1 : cnt);
    assign capture   = enable && one_next && !changed && (state == TRACK) && (cnt == STABLE_MAX);
    assign multi_err = enable && !none_next && !one_next && !changed && (cnt == STABLE_PRE);
    assign mask_new  = mask | low_cur;
    assign dec       = decode(sync2[6:0]);

    // Locate the single low anode of the current sample
    always_comb begin
        cur_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (low_cur[i]) cur_idx = 3'(i);
        end
    end

    // Synchronizer, stability counter, scan FSM and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= '1;
            sync2       <= '1;
            cnt         <= '0;
            state       <= IDLE;
            mask        <= '0;
            digits_out  <= '0;
            digit_valid <= 1'b0;
            digit_idx   <= '0;
            digit_val   <= '0;
            pattern_err <= 1'b0;
            err_sticky  <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            sync1       <= {anodo, catodo};
            sync2       <= sync1;
            digit_valid <= 1'b0;
            pattern_err <= 1'b0;
            frame_done  <= 1'b0;

            if (!enable || none_next) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (!one_next) begin
                state <= IDLE;
                cnt   <= cnt_next;
            end else begin
                cnt <= cnt_next;
                if (changed) begin
                    state <= TRACK;
                end else if (capture) begin
                    state <= CAPTURED;
                end else if (state == IDLE) begin
                    state <= TRACK;
                end
            end

            if (capture) begin
                digit_idx <= cur_idx;
                if (dec[4]) begin
                    digit_valid <= 1'b1;
                    digit_val   <= dec[3:0];
                    if (!clear) begin
                        for (int i = 0; i < NUM_DIGITS; i++) begin
                            if (cur_idx == 3'(i)) digits_out[4*i +: 4] <= dec[3:0];
                        end
                        if (mask_new == '1) begin
                            frame_done <= 1'b1;
                            mask       <= '0;
                        end else begin
                            mask <= mask_new;
                        end
                    end
                end else begin
                    pattern_err <= 1'b1;
                    if (!clear) err_sticky <= 1'b1;
                end
            end

            if (multi_err && !clear) err_sticky <= 1'b1;

            if (clear) begin
                digits_out <= '0;
                mask       <= '0;
                err_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_reader.sv
// Testbench for seg_scan_reader: directed display-bus vectors.
// Expected capture events go into a scoreboard queue, and a monitor
// compares them whenever the DUT pulses digit_valid, pattern_err or frame_done.
module tb_seg_scan_reader;

    localparam int ND = 4;
    localparam int SC = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [ND-1:0] anodo = '1;
    logic [6:0]    catodo = '1;
    logic          enable = 1'b1;
    logic          clear = 1'b0;
    logic [4*ND-1:0] digits_out;
    logic          digit_valid;
    logic [2:0]    digit_idx;
    logic [3:0]    digit_val;
    logic          pattern_err;
    logic          err_sticky;
    logic          frame_done;

    typedef struct {
        logic        perr;
        logic [2:0]  idx;
        logic [3:0]  val;
        logic        frame;
        logic [15:0] digits;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    seg_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .anodo      (anodo),
        .catodo     (catodo),
        .enable     (enable),
        .clear      (clear),
        .digits_out (digits_out),
        .digit_valid(digit_valid),
        .digit_idx  (digit_idx),
        .digit_val  (digit_val),
        .pattern_err(pattern_err),
        .err_sticky (err_sticky),
        .frame_done (frame_done)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used to check pin-to-capture latency
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [ND-1:0] an, input logic [6:0] cat, output int start);
        @(posedge clk);
        #1;
        anodo  = an;
        catodo = cat;
        start  = cyc;
    endtask

    task automatic expectEvent(input logic perr, input logic [2:0] idx, input logic [3:0] val,
                               input logic frame, input logic [15:0] digits, input int at);
        exp_t e;
        e.perr = perr; e.idx = idx; e.val = val; e.frame = frame; e.digits = digits; e.at = at;
        sb.push_back(e);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic pulseClear();
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
    endtask

    // Monitor: pop and compare an expected event whenever the DUT pulses an event output
    always @(negedge clk) begin
        if (rst_n && (digit_valid || pattern_err || frame_done)) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_event: got valid=%0b perr=%0b frame=%0b idx=%0d, expected no event (cycle %0d)",
                         digit_valid, pattern_err, frame_done, digit_idx, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("digit_valid", 32'(digit_valid), 32'(!e.perr));
                checkOutput("pattern_err", 32'(pattern_err), 32'(e.perr));
                checkOutput("digit_idx", 32'(digit_idx), 32'(e.idx));
                checkOutput("digit_val", 32'(digit_val), 32'(e.val));
                checkOutput("frame_done", 32'(frame_done), 32'(e.frame));
                checkOutput("digits_out", 32'(digits_out), 32'(e.digits));
                checkOutput("capture_cycle", cyc, e.at);
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected end of sequence");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "[TB] timeout");
    end

    // Directed stimulus sequence
    initial begin
        int st;

        // Reset state
        @(negedge clk);
        checkOutput("rst_digits_out", 32'(digits_out), 32'h0);
        checkOutput("rst_digit_valid", 32'(digit_valid), 32'h0);
        checkOutput("rst_digit_idx", 32'(digit_idx), 32'h0);
        checkOutput("rst_digit_val", 32'(digit_val), 32'h0);
        checkOutput("rst_pattern_err", 32'(pattern_err), 32'h0);
        checkOutput("rst_err_sticky", 32'(err_sticky), 32'h0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'h0);
        rst_n = 1'b1;
        waitCycles(20);
        @(negedge clk);
        checkOutput("idle_err_sticky", 32'(err_sticky), 32'h0);
        checkOutput("idle_digits_out", 32'(digits_out), 32'h0);

        // Single capture: digit 2 shows 7
        applyStimulus(4'b1011, 7'b0001111, st);
        expectEvent(1'b0, 3'd2, 4'd7, 1'b0, 16'h0700, st + SC + 2);
        waitCycles(12);

        // Glitch: too short to capture
        applyStimulus(4'b1110, 7'b0010010, st);
        waitCycles(4);
        applyStimulus(4'b1111, 7'b1111111, st);
        waitCycles(12);
        @(negedge clk);
        checkOutput("glitch_digits_out", 32'(digits_out), 32'h0700);

        // Full frame 1,2,3,4 on digits 0..3 (digit 2 already in the mask)
        applyStimulus(4'b1110, 7'b1001111, st);
        expectEvent(1'b0, 3'd0, 4'd1, 1'b0, 16'h0701, st + SC + 2);
        waitCycles(10);
        applyStimulus(4'b1101, 7'b0010010, st);
        expectEvent(1'b0, 3'd1, 4'd2, 1'b0, 16'h0721, st + SC + 2);
        waitCycles(10);
        applyStimulus(4'b1011, 7'b0000110, st);
        expectEvent(1'b0, 3'd2, 4'd3, 1'b0, 16'h0321, st + SC + 2);
        waitCycles(10);
        applyStimulus(4'b0111, 7'b1001100, st);
        expectEvent(1'b0, 3'd3, 4'd4, 1'b1, 16'h4321, st + SC + 2);
        waitCycles(10);
        // Mask restarted: a single new digit must not complete a frame
        applyStimulus(4'b1110, 7'b0000100, st);
        expectEvent(1'b0, 3'd0, 4'd9, 1'b0, 16'h4329, st + SC + 2);
        waitCycles(10);

        // enable dropped mid-track abandons the capture
        applyStimulus(4'b1110, 7'b0000001, st);
        waitCycles(5);
        #1 enable = 1'b0;
        waitCycles(4);
        applyStimulus(4'b1111, 7'b1111111, st);
        enable = 1'b1;
        waitCycles(12);
        @(negedge clk);
        checkOutput("enable_digits_out", 32'(digits_out), 32'h4329);

        // Invalid (blank) pattern on digit 1
        applyStimulus(4'b1101, 7'b1111111, st);
        expectEvent(1'b1, 3'd1, 4'd9, 1'b0, 16'h4329, st + SC + 2);
        waitCycles(10);
        @(negedge clk);
        checkOutput("perr_err_sticky", 32'(err_sticky), 32'h1);
        applyStimulus(4'b1100, 7'b0000110, st);
        waitCycles(12);
        pulseClear();
        @(negedge clk);
        checkOutput("clear_err_sticky", 32'(err_sticky), 32'h0);
        checkOutput("clear_digits_out", 32'(digits_out), 32'h0);
        // Same multi-anode hold continues: no second error
        waitCycles(5);
        @(negedge clk);
        checkOutput("multi_once_err_sticky", 32'(err_sticky), 32'h0);
        // New multi-anode hold flags an anode error
        applyStimulus(4'b0011, 7'b0000110, st);
        waitCycles(12);
        @(negedge clk);
        checkOutput("multi_err_sticky", 32'(err_sticky), 32'h1);
        pulseClear();
        @(negedge clk);
        checkOutput("clear2_err_sticky", 32'(err_sticky), 32'h0);

        // Reset mid-track
        applyStimulus(4'b1101, 7'b0010010, st);
        waitCycles(4);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_digit_idx", 32'(digit_idx), 32'h0);
        checkOutput("midrst_digit_val", 32'(digit_val), 32'h0);
        waitCycles(2);
        @(posedge clk);
        #1 rst_n = 1'b1;
        st = cyc;
        expectEvent(1'b0, 3'd1, 4'd2, 1'b0, 16'h0020, st + SC + 2);
        waitCycles(12);

        // clear in the same cycle as a capture suppresses the slot write
        applyStimulus(4'b1101, 7'b0100100, st);
        expectEvent(1'b0, 3'd1, 4'd5, 1'b0, 16'h0000, st + SC + 2);
        waitCycles(SC + 1);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        waitCycles(3);
        @(negedge clk);
        checkOutput("clrcap_digits_out", 32'(digits_out), 32'h0);

        waitCycles(3);
        @(negedge clk);
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL missing_event: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
